// File: rtl/sysled_blinker_if.sv
// Avalon-MM slave bus bundle for the system-LED blinker register file.
interface sysled_blinker_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );
endinterface

// File: rtl/sysled_blinker.sv
// System-LED blinker: passes the PIO level through, or shifts a 32-bit pattern out to the LED.
// Defining SYSLED_BLINKER_IRQ_EN adds a registered irq output and a writable CONTROL.IRQEN bit.
module sysled_blinker #(
    parameter int unsigned PRESCALE_W   = 24,
    parameter logic [31:0] INIT_PATTERN = 32'hAAAA_AAAA
) (
    input  logic             clk,
    input  logic             reset,
    sysled_blinker_if.slave  bus,
    input  logic             pio_in,
    output logic             led_out
`ifdef SYSLED_BLINKER_IRQ_EN
    ,
    output logic             irq
`endif
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]            state_q, state_d;
    logic                  run_q, run_d;
    logic                  gate_q, gate_d;
    logic                  oneshot_q, oneshot_d;
    logic                  invert_q, invert_d;
    logic                  irqen_q, irqen_d;
    logic [PRESCALE_W-1:0] period_q, period_d;
    logic [PRESCALE_W-1:0] presc_q, presc_d;
    logic [31:0]           pattern_q, pattern_d;
    logic                  done_q, done_d;
    logic [4:0]            index_q, index_d;
    logic                  led_q, led_d;

    logic                  wr_ctrl, wr_period, wr_pattern, wr_status;
    logic                  advance, tick, done_set;
    logic [31:0]           period_rd;

    always_comb begin
        wr_ctrl    = bus.chipselect && !bus.write_n && (bus.address == 2'd0);
        wr_period  = bus.chipselect && !bus.write_n && (bus.address == 2'd1);
        wr_pattern = bus.chipselect && !bus.write_n && (bus.address == 2'd2);
        wr_status  = bus.chipselect && !bus.write_n && (bus.address == 2'd3);
        advance    = (state_q == ST_RUN) && (!gate_q || pio_in);
        tick       = advance && (presc_q == '0);
    end

    // A stop request overrides any tick in the same cycle so the index stays where it was.
    always_comb begin
        state_d   = state_q;
        run_d     = run_q;
        gate_d    = gate_q;
        oneshot_d = oneshot_q;
        invert_d  = invert_q;
        irqen_d   = irqen_q;
        period_d  = period_q;
        pattern_d = pattern_q;
        presc_d   = presc_q;
        index_d   = index_q;
        done_set  = 1'b0;

        if (wr_period) begin
            period_d = bus.writedata[PRESCALE_W-1:0];
        end
        if (wr_pattern) begin
            pattern_d = bus.writedata;
        end
        if (wr_ctrl) begin
            run_d     = bus.writedata[0];
            gate_d    = bus.writedata[1];
            oneshot_d = bus.writedata[2];
            invert_d  = bus.writedata[3];
`ifdef SYSLED_BLINKER_IRQ_EN
            irqen_d   = bus.writedata[4];
`endif
        end

        if (wr_ctrl && !bus.writedata[0]) begin
            state_d = ST_IDLE;
        end else if (wr_ctrl && (state_q != ST_RUN)) begin
            state_d = ST_RUN;
            index_d = '0;
            presc_d = period_q;
        end else if (advance) begin
            if (tick) begin
                presc_d = period_q;
                index_d = index_q + 5'd1;
                if ((index_q == 5'd31) && oneshot_q) begin
                    state_d  = ST_DONE;
                    run_d    = 1'b0;
                    done_set = 1'b1;
                end
            end else begin
                presc_d = presc_q - PRESCALE_W'(1);
            end
        end

        done_d = done_q;
        if (wr_status && bus.writedata[1]) begin
            done_d = 1'b0;
        end
        if (done_set) begin
            done_d = 1'b1;
        end

        case (state_q)
            ST_RUN:  led_d = pattern_q[index_q] ^ invert_q;
            ST_DONE: led_d = invert_q;
            default: led_d = pio_in ^ invert_q;
        endcase
    end

    always_comb begin
        period_rd                   = '0;
        period_rd[PRESCALE_W-1:0]   = period_q;
        case (bus.address)
            2'd0:    bus.readdata = {27'd0, irqen_q, invert_q, oneshot_q, gate_q, run_q};
            2'd1:    bus.readdata = period_rd;
            2'd2:    bus.readdata = pattern_q;
            default: bus.readdata = {19'd0, index_q, 6'd0, done_q, (state_q == ST_RUN)};
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            run_q     <= 1'b0;
            gate_q    <= 1'b0;
            oneshot_q <= 1'b0;
            invert_q  <= 1'b0;
            irqen_q   <= 1'b0;
            period_q  <= '1;
            pattern_q <= INIT_PATTERN;
            presc_q   <= '0;
            index_q   <= '0;
            done_q    <= 1'b0;
            led_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            run_q     <= run_d;
            gate_q    <= gate_d;
            oneshot_q <= oneshot_d;
            invert_q  <= invert_d;
            irqen_q   <= irqen_d;
            period_q  <= period_d;
            pattern_q <= pattern_d;
            presc_q   <= presc_d;
            index_q   <= index_d;
            done_q    <= done_d;
            led_q     <= led_d;
        end
    end

    assign led_out = led_q;

`ifdef SYSLED_BLINKER_IRQ_EN
    logic irq_q, irq_d;

    always_comb begin
        irq_d = done_q && irqen_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign irq = irq_q;
`endif

endmodule
